// File: rtl/game_flow_ctrl.sv
// Game-flow controller for the pong family: match sequencing, BCD score counters, serve/over timer, winner.
// Define GAME_FLOW_AUTOSERVE_EN to leave NEWBALL as soon as the serve timer expires, without a start press.
module game_flow_ctrl #(
   parameter int N_PLAYERS   = 2,
   parameter int DIGITS      = 2,
   parameter int WIN_SCORE   = 99,
   parameter int SERVE_TICKS = 120,
   parameter int OVER_TICKS  = 120
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       frame_tick,
   input  logic                                       start,
   input  logic                                       pause,
   input  logic [N_PLAYERS-1:0]                       point,
   output logic [2:0]                                 state,
   output logic                                       gra_still,
   output logic [N_PLAYERS*DIGITS*4-1:0]              score,
   output logic [((N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1)-1:0] winner,
   output logic                                       winner_valid
);

   localparam int SW   = DIGITS * 4;
   localparam int SCW  = N_PLAYERS * SW;
   localparam int WW   = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
   localparam int TMAX = (SERVE_TICKS > OVER_TICKS) ? SERVE_TICKS : OVER_TICKS;
   localparam int TW   = ($clog2(TMAX + 1) > 0) ? $clog2(TMAX + 1) : 1;

   typedef enum logic [2:0] {
      S_NEWGAME = 3'd0,
      S_PLAY    = 3'd1,
      S_NEWBALL = 3'd2,
      S_OVER    = 3'd3,
      S_PAUSE   = 3'd4
   } state_t;

   function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
      logic [SW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (c) begin
            if (r[d*4 +: 4] == 4'd9) begin
               r[d*4 +: 4] = 4'd0;
            end else begin
               r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [SW-1:0] to_bcd(input int v);
      logic [SW-1:0] r;
      int            t;
      r = '0;
      t = v;
      for (int d = 0; d < DIGITS; d++) begin
         r[d*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_SCORE);

   state_t         r_state, w_state_nx;
   logic [SCW-1:0] r_score, w_score_nx, w_score_inc;
   logic [TW-1:0]  r_timer, w_timer_nx;
   logic [WW-1:0]  r_winner, w_winner_nx, w_win_idx;
   logic           r_winner_valid, w_winner_valid_nx;
   logic           r_start_q, r_pause_q;
   logic           w_start_rise, w_pause_rise, w_win_hit, w_serve_go, w_tick_dec;

   assign w_start_rise = start & ~r_start_q;
   assign w_pause_rise = pause & ~r_pause_q;
   assign w_tick_dec   = frame_tick && (r_timer != '0);

`ifdef GAME_FLOW_AUTOSERVE_EN
   assign w_serve_go = (r_timer == '0);
`else
   assign w_serve_go = (r_timer == '0) && w_start_rise;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_NEWGAME;
         r_score        <= '0;
         r_timer        <= '0;
         r_winner       <= '0;
         r_winner_valid <= 1'b0;
         r_start_q      <= 1'b0;
         r_pause_q      <= 1'b0;
      end else begin
         r_state        <= w_state_nx;
         r_score        <= w_score_nx;
         r_timer        <= w_timer_nx;
         r_winner       <= w_winner_nx;
         r_winner_valid <= w_winner_valid_nx;
         r_start_q      <= start;
         r_pause_q      <= pause;
      end
   end

   always_comb begin
      w_score_inc       = r_score;
      w_win_hit         = 1'b0;
      w_win_idx         = '0;
      w_state_nx        = r_state;
      w_score_nx        = r_score;
      w_timer_nx        = r_timer;
      w_winner_nx       = r_winner;
      w_winner_valid_nx = r_winner_valid;

      // Walk high to low so the lowest index reaching the target is the one kept.
      for (int i = N_PLAYERS - 1; i >= 0; i--) begin
         if (point[i]) begin
            w_score_inc[i*SW +: SW] = bcd_inc(r_score[i*SW +: SW]);
            if (bcd_inc(r_score[i*SW +: SW]) == WIN_BCD) begin
               w_win_hit = 1'b1;
               w_win_idx = WW'(i);
            end
         end
      end

      case (r_state)
         S_NEWGAME: begin
            w_score_nx        = '0;
            w_winner_valid_nx = 1'b0;
            if (w_start_rise) w_state_nx = S_PLAY;
         end
         S_PLAY: begin
            if (|point) begin
               w_score_nx = w_score_inc;
               if (w_win_hit) begin
                  w_state_nx        = S_OVER;
                  w_timer_nx        = TW'(OVER_TICKS);
                  w_winner_nx       = w_win_idx;
                  w_winner_valid_nx = 1'b1;
               end else begin
                  w_state_nx = S_NEWBALL;
                  w_timer_nx = TW'(SERVE_TICKS);
               end
            end else if (w_pause_rise) begin
               w_state_nx = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (w_pause_rise) w_state_nx = S_PLAY;
         end
         S_NEWBALL: begin
            if (w_tick_dec) w_timer_nx = r_timer - TW'(1);
            if (w_serve_go) w_state_nx = S_PLAY;
         end
         S_OVER: begin
            if (r_timer == '0) begin
               w_state_nx        = S_NEWGAME;
               w_score_nx        = '0;
               w_winner_valid_nx = 1'b0;
            end else if (w_tick_dec) begin
               w_timer_nx = r_timer - TW'(1);
            end
         end
         default: begin
            w_state_nx = S_NEWGAME;
         end
      endcase
   end

   assign state        = r_state;
   assign gra_still    = (r_state != S_PLAY);
   assign score        = r_score;
   assign winner       = r_winner;
   assign winner_valid = r_winner_valid;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: two instances (2 players x 2 digits, 3 players x 1 digit) driven by shared
// controls, compared every cycle against an integer-score reference model, plus directed scenarios.
module tb_game_flow_ctrl;

   localparam int SERVE = 120;
   localparam int OVERT = 120;
   localparam int ST_NEWGAME = 0, ST_PLAY = 1, ST_NEWBALL = 2, ST_OVER = 3, ST_PAUSE = 4;

   logic        clk = 1'b0;
   logic        reset, frame_tick, start, pause;
   logic [1:0]  point_a;
   logic [2:0]  point_b;
   logic [2:0]  state_a, state_b;
   logic        gs_a, gs_b, wv_a, wv_b;
   logic [15:0] score_a;
   logic [11:0] score_b;
   logic [0:0]  winner_a;
   logic [1:0]  winner_b;

   int n_checks = 0;
   int n_errors = 0;

   game_flow_ctrl #(.N_PLAYERS(2), .DIGITS(2), .WIN_SCORE(15), .SERVE_TICKS(SERVE), .OVER_TICKS(OVERT)) u_dut_a (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .pause(pause), .point(point_a),
      .state(state_a), .gra_still(gs_a), .score(score_a), .winner(winner_a), .winner_valid(wv_a));

   game_flow_ctrl #(.N_PLAYERS(3), .DIGITS(1), .WIN_SCORE(3), .SERVE_TICKS(SERVE), .OVER_TICKS(OVERT)) u_dut_b (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .pause(pause), .point(point_b),
      .state(state_b), .gra_still(gs_b), .score(score_b), .winner(winner_b), .winner_valid(wv_b));

   always #5 clk = ~clk;

   // Reference model: scores kept as plain integers, one slot per instance.
   int m_state [2];
   int m_sc    [2][4];
   int m_timer [2];
   int m_win   [2];
   bit m_wv    [2];
   bit m_sq    [2];
   bit m_pq    [2];

   function automatic int np(input int k);   return (k == 0) ? 2 : 3;   endfunction
   function automatic int nd(input int k);   return (k == 0) ? 2 : 1;   endfunction
   function automatic int ntgt(input int k); return (k == 0) ? 15 : 3;  endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_state[k] = ST_NEWGAME;
         m_timer[k] = 0;
         m_win[k]   = 0;
         m_wv[k]    = 1'b0;
         m_sq[k]    = 1'b0;
         m_pq[k]    = 1'b0;
         for (int i = 0; i < 4; i++) m_sc[k][i] = 0;
      end
   endfunction

   function automatic void model_step(input int k, input bit st, input bit pz, input bit tk, input bit [3:0] pts);
      bit sr, pr, go;
      int hit;
      sr = st && !m_sq[k];
      pr = pz && !m_pq[k];
      case (m_state[k])
         ST_NEWGAME: begin
            for (int i = 0; i < 4; i++) m_sc[k][i] = 0;
            m_wv[k] = 1'b0;
            if (sr) m_state[k] = ST_PLAY;
         end
         ST_PLAY: begin
            if (pts != 4'd0) begin
               hit = -1;
               for (int i = 0; i < np(k); i++) begin
                  if (pts[i]) begin
                     m_sc[k][i] = (m_sc[k][i] + 1) % (10 ** nd(k));
                     if (m_sc[k][i] == ntgt(k) && hit < 0) hit = i;
                  end
               end
               if (hit >= 0) begin
                  m_state[k] = ST_OVER;
                  m_timer[k] = OVERT;
                  m_win[k]   = hit;
                  m_wv[k]    = 1'b1;
               end else begin
                  m_state[k] = ST_NEWBALL;
                  m_timer[k] = SERVE;
               end
            end else if (pr) begin
               m_state[k] = ST_PAUSE;
            end
         end
         ST_PAUSE: if (pr) m_state[k] = ST_PLAY;
         ST_NEWBALL: begin
`ifdef GAME_FLOW_AUTOSERVE_EN
            go = (m_timer[k] == 0);
`else
            go = (m_timer[k] == 0) && sr;
`endif
            if (tk && m_timer[k] > 0) m_timer[k]--;
            if (go) m_state[k] = ST_PLAY;
         end
         ST_OVER: begin
            if (m_timer[k] == 0) begin
               m_state[k] = ST_NEWGAME;
               m_wv[k]    = 1'b0;
               for (int i = 0; i < 4; i++) m_sc[k][i] = 0;
            end else if (tk) begin
               m_timer[k]--;
            end
         end
         default: m_state[k] = ST_NEWGAME;
      endcase
      m_sq[k] = st;
      m_pq[k] = pz;
   endfunction

   function automatic logic [31:0] exp_score(input int k);
      logic [31:0] v;
      int t;
      v = '0;
      for (int i = 0; i < np(k); i++) begin
         t = m_sc[k][i];
         for (int d = 0; d < nd(k); d++) begin
            v[(i*nd(k)+d)*4 +: 4] = 4'(t % 10);
            t = t / 10;
         end
      end
      return v;
   endfunction

   task automatic compare_all();
      check("A.state",  32'(state_a),  32'(m_state[0]));
      check("A.still",  32'(gs_a),     32'(m_state[0] != ST_PLAY));
      check("A.score",  32'(score_a),  exp_score(0));
      check("A.winner", 32'(winner_a), 32'(m_win[0]));
      check("A.wvalid", 32'(wv_a),     32'(m_wv[0]));
      check("B.state",  32'(state_b),  32'(m_state[1]));
      check("B.still",  32'(gs_b),     32'(m_state[1] != ST_PLAY));
      check("B.score",  32'(score_b),  exp_score(1));
      check("B.winner", 32'(winner_b), 32'(m_win[1]));
      check("B.wvalid", 32'(wv_b),     32'(m_wv[1]));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".A.state"},  32'(state_a),  32'd0);
      check({tag, ".A.still"},  32'(gs_a),     32'd1);
      check({tag, ".A.score"},  32'(score_a),  32'd0);
      check({tag, ".A.winner"}, 32'(winner_a), 32'd0);
      check({tag, ".A.wvalid"}, 32'(wv_a),     32'd0);
      check({tag, ".B.state"},  32'(state_b),  32'd0);
      check({tag, ".B.score"},  32'(score_b),  32'd0);
      check({tag, ".B.wvalid"}, 32'(wv_b),     32'd0);
   endtask

   // Called at a falling edge: drive, let the rising edge happen, update model, compare at next falling edge.
   task automatic cyc(input bit s, input bit p, input bit t, input bit [1:0] pa, input bit [2:0] pb);
      start = s; pause = p; frame_tick = t; point_a = pa; point_b = pb;
      @(posedge clk);
      model_step(0, s, p, t, {2'b00, pa});
      model_step(1, s, p, t, {1'b0, pb});
      @(negedge clk);
      compare_all();
   endtask

   task automatic serve();
      repeat (SERVE) cyc(1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
      cyc(1'b1, 1'b0, 1'b0, 2'b00, 3'b000);
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
   endtask

   task automatic point_serve(input bit [1:0] pa, input bit [2:0] pb);
      cyc(1'b0, 1'b0, 1'b0, pa, pb);
      serve();
   endtask

   task automatic async_reset();
      #2 reset = 1'b1;
      #1;
      check_reset_vals("async_rst");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      bit         rs, rp, rt;
      bit [1:0]   ra;
      bit [2:0]   rb;
      reset = 1'b1; start = 1'b1; pause = 1'b0; frame_tick = 1'b0; point_a = '0; point_b = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      reset = 1'b0;

      // start held through reset release counts as a rise
      cyc(1'b1, 1'b0, 1'b0, 2'b00, 3'b000);
      check("start_to_play", 32'(state_a), 32'd1);
      check("play_still",    32'(gs_a),    32'd0);

      cyc(1'b1, 1'b0, 1'b1, 2'b10, 3'b000);
      check("p1_point_score", 32'(score_a), 32'h0100);
      check("p1_point_state", 32'(state_a), 32'd2);

      repeat (SERVE - 1) cyc(1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
      cyc(1'b1, 1'b0, 1'b1, 2'b00, 3'b000);
      check("early_start", 32'(state_a), 32'd2);
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
      cyc(1'b1, 1'b0, 1'b0, 2'b00, 3'b000);
      check("serve_play", 32'(state_a), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 3'b000);

      repeat (9) point_serve(2'b01, 3'b000);
      check("score_09", 32'(score_a), 32'h0109);
      point_serve(2'b01, 3'b000);
      check("bcd_carry", 32'(score_a), 32'h0110);

      cyc(1'b0, 1'b1, 1'b0, 2'b00, 3'b000);
      check("pause_enter", 32'(state_a), 32'd4);
      cyc(1'b0, 1'b1, 1'b0, 2'b11, 3'b111);
      cyc(1'b0, 1'b0, 1'b0, 2'b11, 3'b111);
      check("pause_hold", 32'(score_a), 32'h0110);
      cyc(1'b0, 1'b1, 1'b0, 2'b00, 3'b000);
      check("pause_exit", 32'(state_a), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
      cyc(1'b0, 1'b1, 1'b0, 2'b01, 3'b010);
      check("point_beats_pause", 32'(state_a), 32'd2);
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
      serve();

      point_serve(2'b00, 3'b101);
      point_serve(2'b00, 3'b101);
      cyc(1'b0, 1'b0, 1'b0, 2'b00, 3'b101);
      check("tie_state",  32'(state_b),  32'd3);
      check("tie_winner", 32'(winner_b), 32'd0);
      check("tie_valid",  32'(wv_b),     32'd1);
      check("tie_score",  32'(score_b),  32'h313);
      repeat (OVERT + 1) cyc(1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
      check("over_exit",  32'(state_b), 32'd0);
      check("over_clear", 32'(score_b), 32'd0);

      rs = 1'b0;
      rp = 1'b0;
      for (int i = 0; i < 24000; i++) begin
         if ($urandom_range(3) == 0)  rs = ~rs;
         if ($urandom_range(31) == 0) rp = ~rp;
         rt = ($urandom_range(3) != 0);
         ra = ($urandom_range(5) == 0) ? 2'($urandom) : 2'b00;
         rb = ($urandom_range(5) == 0) ? 3'($urandom) : 3'b000;
         cyc(rs, rp, rt, ra, rb);
         if (i == 12000) async_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
